// File: rtl/pid_pkg.sv
// pid_pkg: shared definitions for the PID compute stage.
// Holds the FSM state encoding, default widths and accumulator width rule.
package pid_pkg;

   localparam int ERR_W = 16;
   localparam int OUT_W = 16;
   localparam int INT_W = 24;

   // 6-bit unsigned gain (7 bits signed) times INT_W+1 operand, plus
   // headroom for summing three terms.
   function automatic int acc_width(input int iw);
      return iw + 9;
   endfunction

   localparam int ACC_W = acc_width(INT_W);

   typedef enum logic [2:0] {
      IDLE,
      TERM_P,
      TERM_I,
      TERM_D,
      OUT
   } state_t;

endpackage

// File: rtl/pid_sat.sv
// pid_sat: signed saturating clamp from IN_W to OUT_W bits.
// Ports: din (IN_W signed), dout (OUT_W signed), clamped (limit hit).
module pid_sat #(
   parameter int IN_W   = 25,
   parameter int OUT_W  = 24,
   parameter int LIM_HI = 1048575,
   parameter int LIM_LO = -1048575
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout,
   output logic                    clamped
);

   localparam logic signed [IN_W-1:0] HI = IN_W'(LIM_HI);
   localparam logic signed [IN_W-1:0] LO = IN_W'(LIM_LO);

   always_comb begin
      dout    = din[OUT_W-1:0];
      clamped = 1'b0;
      if (din > HI) begin
         dout    = HI[OUT_W-1:0];
         clamped = 1'b1;
      end else if (din < LO) begin
         dout    = LO[OUT_W-1:0];
         clamped = 1'b1;
      end
   end

endmodule

// File: rtl/pid_core.sv
// pid_core: fixed-point PID stage, one shared multiplier over a 5-state FSM.
// Ports: clk_50m, rst_n, KP/KI/KD gains, sample_valid/error/integ_clr in;
//        ready, out_valid, ctrl_out, sat, overrun out.
module pid_core #(
   parameter int ERR_W = pid_pkg::ERR_W,
   parameter int OUT_W = pid_pkg::OUT_W,
   parameter int INT_W = pid_pkg::INT_W,
   parameter int I_LIM = 1048575,
   parameter int SHIFT = 4
) (
   input  logic                    clk_50m,
   input  logic                    rst_n,
   input  logic [5:0]              KP,
   input  logic [5:0]              KI,
   input  logic [5:0]              KD,
   input  logic                    sample_valid,
   input  logic signed [ERR_W-1:0] error,
   input  logic                    integ_clr,
   output logic                    ready,
   output logic                    out_valid,
   output logic signed [OUT_W-1:0] ctrl_out,
   output logic                    sat,
   output logic                    overrun
);

   import pid_pkg::*;

   localparam int ACC_W = acc_width(INT_W);

   state_t state, state_nx;

   logic accept;
   logic [5:0] g_kp, g_ki, g_kd;
   logic signed [ERR_W-1:0] e_lat, e_prev, p_base;
   logic signed [INT_W-1:0] integ, i_op, i_base, i_next;
   logic signed [INT_W:0] i_sum;
   logic i_clamped_unused;
   logic signed [ERR_W:0] deriv;
   logic signed [ACC_W-1:0] acc, acc_sh;
   logic signed [6:0] m_a;
   logic signed [INT_W:0] m_b;
   logic signed [INT_W+7:0] prod;
   logic signed [OUT_W-1:0] o_next;
   logic o_clamped;

   assign accept = sample_valid && ready;

   // A clear in the accept cycle takes effect before the new sample.
   assign i_base = integ_clr ? '0 : integ;
   assign p_base = integ_clr ? '0 : e_prev;
   assign i_sum  = (INT_W+1)'(i_base) + (INT_W+1)'(error);

   pid_sat #(
      .IN_W   (INT_W + 1),
      .OUT_W  (INT_W),
      .LIM_HI (I_LIM),
      .LIM_LO (-I_LIM)
   ) u_isat (
      .din     (i_sum),
      .dout    (i_next),
      .clamped (i_clamped_unused)
   );

   assign acc_sh = acc >>> SHIFT;

   pid_sat #(
      .IN_W   (ACC_W),
      .OUT_W  (OUT_W),
      .LIM_HI (2**(OUT_W-1) - 1),
      .LIM_LO (-(2**(OUT_W-1)))
   ) u_osat (
      .din     (acc_sh),
      .dout    (o_next),
      .clamped (o_clamped)
   );

   always_comb begin
      m_a = '0;
      m_b = '0;
      unique case (1'b1)
         (state == TERM_P): begin
            m_a = {1'b0, g_kp};
            m_b = (INT_W+1)'(e_lat);
         end
         (state == TERM_I): begin
            m_a = {1'b0, g_ki};
            m_b = (INT_W+1)'(i_op);
         end
         (state == TERM_D): begin
            m_a = {1'b0, g_kd};
            m_b = (INT_W+1)'(deriv);
         end
         default: ;
      endcase
   end

   assign prod = m_a * m_b;

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = TERM_P;
         TERM_P:  state_nx = TERM_I;
         TERM_I:  state_nx = TERM_D;
         TERM_D:  state_nx = OUT;
         OUT:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      ready = (state == IDLE);
   end

   // i_op snapshots the updated integrator so a later clear cannot
   // disturb the sample already in flight.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         g_kp   <= '0;
         g_ki   <= '0;
         g_kd   <= '0;
         e_lat  <= '0;
         e_prev <= '0;
         integ  <= '0;
         i_op   <= '0;
         deriv  <= '0;
      end else if (accept) begin
         g_kp   <= KP;
         g_ki   <= KI;
         g_kd   <= KD;
         e_lat  <= error;
         e_prev <= error;
         integ  <= i_next;
         i_op   <= i_next;
         deriv  <= (ERR_W+1)'(error) - (ERR_W+1)'(p_base);
      end else if (integ_clr) begin
         e_prev <= '0;
         integ  <= '0;
      end
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         ctrl_out  <= '0;
         sat       <= 1'b0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         out_valid <= (state == OUT);
         overrun   <= sample_valid && !ready;
         unique case (state)
            TERM_P: acc <= ACC_W'(prod);
            TERM_I: acc <= acc + ACC_W'(prod);
            TERM_D: acc <= acc + ACC_W'(prod);
            OUT: begin
               ctrl_out <= o_next;
               sat      <= o_clamped;
            end
            default: ;
         endcase
      end
   end

endmodule
